truth_table_scanner: RTL and testbench
======================================

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 SHALL have parameter SETTLE, default 0, extra hold cycles per minterm before sampling (0..15).
REQ-002 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request a full 8-minterm scan; sampled only in IDLE.
REQ-005 SHALL have port d_level  input  1  value driven on d for the whole scan; captured at start.
REQ-006 SHALL have port expected  input  8  expected e truth table, bit i = e for {a,b,c}=i; captured at start.
REQ-007 SHALL have port e_in  input  1  e response from the downstream 3-input function stage.
REQ-008 SHALL have port f_in  input  1  f response (e AND d) from the downstream stage.
REQ-009 SHALL have ports a, b, c  output  1 each  stimulus to the stage; {a,b,c} = minterm index, a = MSB.
REQ-010 SHALL have port d  output  1  stimulus enable to the stage's AND gate.
REQ-011 SHALL have port e_table  output  8  captured e values, bit i for minterm i.
REQ-012 SHALL have port f_table  output  8  captured f values, bit i for minterm i.
REQ-013 SHALL have port ones_count  output  4  number of minterms with e_in=1 (0..8).
REQ-014 SHALL have ports busy, done, mismatch  output  1 each  scan active / one-cycle completion pulse / e_table != expected.

Function
REQ-015 SHALL implement FSM states IDLE, APPLY, SAMPLE, DONE; all outputs registered.
REQ-016 IDLE: {a,b,c}=000, d=0, busy=0, done=0; tables, ones_count, mismatch hold last scan result.
REQ-017 IDLE with start=1 SHALL go to APPLY, set idx=0, clear e_table, f_table, ones_count, mismatch, and latch d_level and expected.
REQ-018 APPLY: {a,b,c}=idx, d=latched d_level, busy=1; hold for SETTLE cycles (settle counter), then go to SAMPLE; SETTLE=0 means exactly one APPLY cycle.
REQ-019 SAMPLE: {a,b,c},d unchanged; on the edge leaving SAMPLE, e_table[idx]<=e_in, f_table[idx]<=f_in, ones_count += e_in.
REQ-020 SAMPLE with idx<7 SHALL increment idx and return to APPLY; idx=7 SHALL go to DONE (no wrap to 0 within a scan).
REQ-021 DONE: busy=0, done=1 for exactly one cycle, mismatch<=(e_table != latched expected), {a,b,c}=000, d=0; next state IDLE.
REQ-022 Scan latency SHALL be 16+8*SETTLE cycles from the start-sampling edge to the edge that asserts done.
REQ-023 start while busy or in DONE SHALL be ignored; latched d_level/expected SHALL NOT change mid-scan.
REQ-024 start held high through DONE SHALL launch a new scan from IDLE on the cycle after done.
REQ-025 ones_count SHALL be 4 bits and saturate impossible by construction (max 8).

Reset
REQ-026 reset=1 SHALL immediately (asynchronously) force IDLE, idx=0, settle counter=0, {a,b,c}=000, d=0, busy=0, done=0, mismatch=0, e_table=0, f_table=0, ones_count=0.
REQ-027 reset asserted mid-scan SHALL abort the scan with no done pulse; first scan after release requires a new start.
REQ-028 Outputs SHALL remain at reset values until first start after reset deasserts.

Verification
REQ-029 SETTLE=0, d_level=1, expected=8'hD5, stage = f(0,2,4,6,7) -> done at cycle 16, e_table=8'hD5, f_table=8'hD5, ones_count=5, mismatch=0.
REQ-030 Same stage, d_level=0 -> e_table=8'hD5, f_table=8'h00, ones_count=5, d low whole scan.
REQ-031 expected=8'hD4 with same stage -> mismatch=1 in DONE cycle, done pulse one cycle wide.
REQ-032 SETTLE=3 -> each minterm held 4 APPLY + 1 SAMPLE cycle, done at cycle 40, results as REQ-029.
REQ-033 reset pulsed during minterm 4 -> all outputs zero immediately, no done; subsequent start gives correct full scan.
REQ-034 start held continuously -> back-to-back scans, start ignored while busy, second scan starts cycle after done.

Source files
------------

// File: rtl/truth_table_scanner.sv
// Walks {a,b,c} through all eight minterms, captures the downstream stage's
// e/f responses per minterm and flags any difference from the expected e table.
module truth_table_scanner #(
   parameter int SETTLE = 0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic       d_level,
   input  logic [7:0] expected,
   input  logic       e_in,
   input  logic       f_in,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       d,
   output logic [7:0] e_table,
   output logic [7:0] f_table,
   output logic [3:0] ones_count,
   output logic       busy,
   output logic       done,
   output logic       mismatch
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_APPLY,
      ST_SAMPLE,
      ST_DONE
   } state_t;

   localparam logic [3:0] LP_SETTLE = 4'(SETTLE);

   state_t     r_state;
   state_t     w_state_next;
   logic [2:0] r_idx;
   logic [3:0] r_cnt;
   logic [2:0] r_abc;
   logic       r_d;
   logic [7:0] r_e_table;
   logic [7:0] r_f_table;
   logic [7:0] r_expected;
   logic [3:0] r_ones;
   logic       r_busy;
   logic       r_done;
   logic       r_mismatch;
   logic [7:0] w_e_final;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:   if (start) w_state_next = ST_APPLY;
         ST_APPLY:  if (r_cnt == LP_SETTLE) w_state_next = ST_SAMPLE;
         ST_SAMPLE: w_state_next = (r_idx == 3'd7) ? ST_DONE : ST_APPLY;
         ST_DONE:   w_state_next = ST_IDLE;
         default:   w_state_next = ST_IDLE;
      endcase
   end

   // The compare at the end of the scan must include the minterm-7 sample
   // being written on the same edge.
   always_comb begin
      w_e_final    = r_e_table;
      w_e_final[7] = e_in;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_idx      <= 3'd0;
         r_cnt      <= 4'd0;
         r_abc      <= 3'd0;
         r_d        <= 1'b0;
         r_e_table  <= 8'd0;
         r_f_table  <= 8'd0;
         r_expected <= 8'd0;
         r_ones     <= 4'd0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_mismatch <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_idx      <= 3'd0;
                  r_cnt      <= 4'd0;
                  r_abc      <= 3'd0;
                  r_d        <= d_level;
                  r_e_table  <= 8'd0;
                  r_f_table  <= 8'd0;
                  r_ones     <= 4'd0;
                  r_mismatch <= 1'b0;
                  r_expected <= expected;
                  r_busy     <= 1'b1;
               end
            end
            ST_APPLY: begin
               if (r_cnt == LP_SETTLE) r_cnt <= 4'd0;
               else                    r_cnt <= r_cnt + 4'd1;
            end
            ST_SAMPLE: begin
               r_e_table[r_idx] <= e_in;
               r_f_table[r_idx] <= f_in;
               r_ones           <= r_ones + {3'd0, e_in};
               if (r_idx == 3'd7) begin
                  r_abc      <= 3'd0;
                  r_d        <= 1'b0;
                  r_busy     <= 1'b0;
                  r_done     <= 1'b1;
                  r_mismatch <= (w_e_final != r_expected);
               end else begin
                  r_idx <= r_idx + 3'd1;
                  r_abc <= r_idx + 3'd1;
               end
            end
            ST_DONE: r_done <= 1'b0;
            default: r_done <= 1'b0;
         endcase
      end
   end

   assign {a, b, c}  = r_abc;
   assign d          = r_d;
   assign e_table    = r_e_table;
   assign f_table    = r_f_table;
   assign ones_count = r_ones;
   assign busy       = r_busy;
   assign done       = r_done;
   assign mismatch   = r_mismatch;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Drives two scanners (SETTLE=0 and SETTLE=3) against a modelled 3-input stage
// and checks the per-cycle stimulus and final tables against a truth-table model.
module tb_truth_table_scanner;

   logic       clock = 1'b0;
   logic       reset;
   logic       start;
   logic       d_level;
   logic [7:0] expected;
   logic [7:0] tt;

   logic       a0, b0, c0, d0, e0, f0, busy0, done0, mis0;
   logic [7:0] et0, ft0;
   logic [3:0] oc0;
   logic       a3, b3, c3, d3, e3, f3, busy3, done3, mis3;
   logic [7:0] et3, ft3;
   logic [3:0] oc3;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   // Downstream stage: e is the truth table tt, f = e AND d.
   assign e0 = tt[{a0, b0, c0}];
   assign f0 = e0 & d0;
   assign e3 = tt[{a3, b3, c3}];
   assign f3 = e3 & d3;

   truth_table_scanner #(.SETTLE(0)) u_dut0 (
      .clock(clock), .reset(reset), .start(start), .d_level(d_level),
      .expected(expected), .e_in(e0), .f_in(f0), .a(a0), .b(b0), .c(c0),
      .d(d0), .e_table(et0), .f_table(ft0), .ones_count(oc0), .busy(busy0),
      .done(done0), .mismatch(mis0));

   truth_table_scanner #(.SETTLE(3)) u_dut3 (
      .clock(clock), .reset(reset), .start(start), .d_level(d_level),
      .expected(expected), .e_in(e3), .f_in(f3), .a(a3), .b(b3), .c(c3),
      .d(d3), .e_table(et3), .f_table(ft3), .ones_count(oc3), .busy(busy3),
      .done(done3), .mismatch(mis3));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected behaviour of one scanner j cycles after the edge that sampled start.
   task automatic check_inst(input string nm, input int s, input int j,
                             input logic [7:0] t, input logic dl, input logic [7:0] ex,
                             input logic [2:0] abc, input logic dd, input logic bz,
                             input logic dn, input logic mis, input logic [7:0] et,
                             input logic [7:0] ft, input logic [3:0] oc);
      int per = s + 2;
      int len = 8 * per;
      if (j < len) begin
         chk({nm, "_busy"}, 32'(bz), 32'd1);
         chk({nm, "_done_early"}, 32'(dn), 32'd0);
         chk({nm, "_abc"}, 32'(abc), 32'(j / per));
         chk({nm, "_d"}, 32'(dd), 32'(dl));
      end else if (j == len) begin
         chk({nm, "_done"}, 32'(dn), 32'd1);
         chk({nm, "_busy_done"}, 32'(bz), 32'd0);
         chk({nm, "_abc_done"}, 32'(abc), 32'd0);
         chk({nm, "_d_done"}, 32'(dd), 32'd0);
         chk({nm, "_e_table"}, 32'(et), 32'(t));
         chk({nm, "_f_table"}, 32'(ft), dl ? 32'(t) : 32'd0);
         chk({nm, "_ones"}, 32'(oc), 32'($countones(t)));
         chk({nm, "_mismatch"}, 32'(mis), 32'(t != ex));
      end else if (j == len + 1) begin
         chk({nm, "_done_width"}, 32'(dn), 32'd0);
         chk({nm, "_busy_idle"}, 32'(bz), 32'd0);
         chk({nm, "_e_hold"}, 32'(et), 32'(t));
         chk({nm, "_mis_hold"}, 32'(mis), 32'(t != ex));
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_abcd0"}, {a0, b0, c0, d0, busy0, done0, mis0}, 32'd0);
      chk({tag, "_tab0"}, {et0, ft0, oc0}, 32'd0);
      chk({tag, "_abcd3"}, {a3, b3, c3, d3, busy3, done3, mis3}, 32'd0);
      chk({tag, "_tab3"}, {et3, ft3, oc3}, 32'd0);
   endtask

   // One scan on both instances; start and the latched inputs are disturbed
   // mid-scan to prove they are ignored.
   task automatic run_scan(input logic [7:0] t, input logic dl, input logic [7:0] ex);
      @(negedge clock);
      tt = t; d_level = dl; expected = ex; start = 1'b1;
      @(negedge clock);
      for (int j = 0; j <= 41; j++) begin
         check_inst("s0", 0, j, t, dl, ex, {a0, b0, c0}, d0, busy0, done0, mis0, et0, ft0, oc0);
         check_inst("s3", 3, j, t, dl, ex, {a3, b3, c3}, d3, busy3, done3, mis3, et3, ft3, oc3);
         start    = (j < 16) ? 1'($urandom_range(0, 1)) : 1'b0;
         d_level  = 1'($urandom_range(0, 1));
         expected = 8'($urandom);
         @(negedge clock);
      end
      start = 1'b0;
   endtask

   initial begin
      logic [7:0] rt;
      reset = 1'b1; start = 1'b0; d_level = 1'b0; expected = 8'h00; tt = 8'hD5;
      #1;
      check_zero("reset");
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (3) @(negedge clock);
      check_zero("post_reset_idle");

      run_scan(8'hD5, 1'b1, 8'hD5);
      run_scan(8'hD5, 1'b0, 8'hD5);
      run_scan(8'hD5, 1'b1, 8'hD4);

      // Asynchronous reset mid-scan, during minterm 4 of the SETTLE=0 instance.
      @(negedge clock);
      tt = 8'hD5; d_level = 1'b1; expected = 8'hD5; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      repeat (8) @(negedge clock);
      chk("pre_abort_abc", 32'({a0, b0, c0}), 32'd4);
      #2 reset = 1'b1;
      #1 check_zero("async_reset");
      @(negedge clock);
      reset = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         chk("no_done_after_abort", 32'({done0, done3, busy0, busy3}), 32'd0);
      end
      check_zero("abort_idle");
      run_scan(8'hD5, 1'b1, 8'hD5);

      // Start held high: SETTLE=0 instance runs back to back, SETTLE=3 ignores it.
      @(negedge clock);
      tt = 8'h5A; d_level = 1'b1; expected = 8'h5A; start = 1'b1;
      @(negedge clock);
      for (int j = 0; j <= 41; j++) begin
         if (j <= 17)
            check_inst("b0", 0, j, 8'h5A, 1'b1, 8'h5A, {a0, b0, c0}, d0, busy0, done0, mis0, et0, ft0, oc0);
         else if (j == 18) begin
            chk("b0_restart_busy", 32'(busy0), 32'd1);
            chk("b0_restart_abc", 32'({a0, b0, c0}), 32'd0);
            chk("b0_restart_clear", 32'({et0, oc0}), 32'd0);
         end else
            check_inst("b0b", 0, j - 18, 8'h5A, 1'b0, 8'h33, {a0, b0, c0}, d0, busy0, done0, mis0, et0, ft0, oc0);
         check_inst("b3", 3, j, 8'h5A, 1'b1, 8'h5A, {a3, b3, c3}, d3, busy3, done3, mis3, et3, ft3, oc3);
         if (j == 17) begin d_level = 1'b0; expected = 8'h33; end
         if (j == 34) start = 1'b0;
         @(negedge clock);
      end

      for (int n = 0; n < 6; n++) begin
         rt = 8'($urandom);
         run_scan(rt, 1'($urandom_range(0, 1)), (n % 2 == 0) ? rt : rt ^ 8'(1 << $urandom_range(0, 7)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
